// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: owns the PC, addresses a synchronous-read ROM and
// presents one qualified instruction per cycle with stall, branch squash and HALT.
module etapa_fetch #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = 4'hF,
  parameter logic [13:0]       NOP_WORD    = 14'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              stall_in,
  input  logic              branch_taken_in,
  input  logic [ADDR_W-1:0] branch_target_in,
  output logic [ADDR_W-1:0] imem_addr_out,
  input  logic [13:0]       imem_data_in,
  output logic [13:0]       instruction_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out,
  output logic              halted_out,
  output logic [15:0]       fetch_count_out
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [15:0]       fetch_count;
  logic              accept;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    valid_out       = 1'b0;
    instruction_out = NOP_WORD;
    accept          = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) state_next = RUN;
      end
      RUN: begin
        // A redirect squashes whatever the ROM is presenting this cycle.
        if (branch_taken_in) begin
          pc_next = branch_target_in;
        end else begin
          valid_out       = 1'b1;
          instruction_out = imem_data_in;
          if (!stall_in) begin
            accept = 1'b1;
            if (imem_data_in[13:10] == HALT_OPCODE) state_next = HALT;
            else                                     pc_next    = pc + ADDR_W'(1);
          end
        end
      end
      HALT: ;
      default: state_next = IDLE;
    endcase
  end

  // The ROM is addressed with next_pc so its registered output lines up with pc.
  assign imem_addr_out   = rst ? RESET_PC : pc_next;
  assign pc_out          = pc;
  assign halted_out      = (state == HALT);
  assign fetch_count_out = fetch_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (accept && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_etapa_fetch.sv
// Self-checking bench for etapa_fetch: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model of the fetch stage.
module tb_etapa_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic [7:0]  branch_target_in = 8'h00;
  logic [7:0]  imem_addr_out, pc_out;
  logic [13:0] imem_data_in, instruction_out;
  logic        valid_out, halted_out;
  logic [15:0] fetch_count_out;

  logic [13:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 = idle, 1 = running, 2 = halted.
  int          m_mode = 0;
  logic [7:0]  m_pc = 8'h00;
  int          m_count = 0;
  logic        e_valid, e_halt;
  logic [13:0] e_instr;
  logic [7:0]  e_pc, e_addr;
  logic [15:0] e_count;

  etapa_fetch dut (
    .clk(clk), .rst(rst), .start_in(start_in), .stall_in(stall_in),
    .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
    .imem_addr_out(imem_addr_out), .imem_data_in(imem_data_in),
    .instruction_out(instruction_out), .pc_out(pc_out), .valid_out(valid_out),
    .halted_out(halted_out), .fetch_count_out(fetch_count_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data_in <= mem[imem_addr_out];

  task automatic model_eval();
    e_valid = (m_mode == 1) && !branch_taken_in;
    e_instr = e_valid ? mem[m_pc] : 14'h0000;
    e_pc    = m_pc;
    e_halt  = (m_mode == 2);
    e_count = 16'(m_count);
    if (rst)                                          e_addr = 8'h00;
    else if (m_mode != 1)                             e_addr = m_pc;
    else if (branch_taken_in)                         e_addr = branch_target_in;
    else if (stall_in || mem[m_pc][13:10] == 4'hF)    e_addr = m_pc;
    else                                              e_addr = m_pc + 8'd1;
  endtask

  task automatic model_advance();
    if (rst) begin
      m_mode = 0; m_pc = 8'h00; m_count = 0;
    end else if (m_mode == 0) begin
      if (start_in) m_mode = 1;
    end else if (m_mode == 1) begin
      if (branch_taken_in) m_pc = branch_target_in;
      else if (!stall_in) begin
        if (m_count < 65535) m_count = m_count + 1;
        if (mem[m_pc][13:10] == 4'hF) m_mode = 2;
        else                          m_pc = m_pc + 8'd1;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    model_advance();
  endtask

  task automatic do_reset();
    rst = 1'b1; start_in = 1'b0; stall_in = 1'b0; branch_taken_in = 1'b0;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    advance();
    settle();
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_out); end
    n_cmp++; if (pc_out !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_pc: got %h expected 00", pc_out); end
    n_cmp++; if (instruction_out !== 14'h0000) begin n_bad++; $display("[TB] FAIL reset_instr: got %h expected 0000", instruction_out); end
    n_cmp++; if (fetch_count_out !== 16'h0000 || halted_out !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_cnt_halt: got %h/%b expected 0000/0", fetch_count_out, halted_out); end
    n_cmp++; if (imem_addr_out !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_addr: got %h expected 00", imem_addr_out); end
    rst = 1'b0;
    advance();
  endtask

  task automatic test_sequential();
    start_in = 1'b1;
    settle();
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_valid: got %b expected 0", valid_out); end
    advance();
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_cmp++; if (pc_out !== 8'(i) || instruction_out !== 14'(i + 16'h10) || valid_out !== 1'b1) begin
        n_bad++; $display("[TB] FAIL seq_fetch%0d: got pc=%h instr=%h v=%b expected pc=%h instr=%h v=1", i, pc_out, instruction_out, valid_out, 8'(i), 14'(i + 16'h10));
      end
      advance();
    end
    settle();
    n_cmp++; if (fetch_count_out !== 16'd4) begin n_bad++; $display("[TB] FAIL seq_count: got %0d expected 4", fetch_count_out); end
    advance();
  endtask

  task automatic test_stall();
    stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_cmp++; if (pc_out !== 8'h05 || instruction_out !== 14'h0015 || imem_addr_out !== 8'h05 || fetch_count_out !== 16'd5) begin
        n_bad++; $display("[TB] FAIL stall_hold%0d: got pc=%h instr=%h addr=%h cnt=%0d expected 05/0015/05/5", k, pc_out, instruction_out, imem_addr_out, fetch_count_out);
      end
      advance();
    end
    stall_in = 1'b0;
    advance();
    settle();
    n_cmp++; if (pc_out !== 8'h06 || instruction_out !== 14'h0016) begin n_bad++; $display("[TB] FAIL stall_release: got pc=%h instr=%h expected 06/0016", pc_out, instruction_out); end
    advance(); advance(); advance();
  endtask

  task automatic test_branch();
    settle();
    n_cmp++; if (pc_out !== 8'h09) begin n_bad++; $display("[TB] FAIL branch_pre_pc: got %h expected 09", pc_out); end
    branch_taken_in = 1'b1; branch_target_in = 8'h40; stall_in = 1'b1;
    settle();
    n_cmp++; if (valid_out !== 1'b0 || instruction_out !== 14'h0000 || imem_addr_out !== 8'h40) begin
      n_bad++; $display("[TB] FAIL branch_squash: got v=%b instr=%h addr=%h expected 0/0000/40", valid_out, instruction_out, imem_addr_out);
    end
    advance();
    branch_taken_in = 1'b0; stall_in = 1'b0;
    settle();
    n_cmp++; if (pc_out !== 8'h40 || instruction_out !== 14'h0050 || valid_out !== 1'b1) begin
      n_bad++; $display("[TB] FAIL branch_target: got pc=%h instr=%h v=%b expected 40/0050/1", pc_out, instruction_out, valid_out);
    end
    advance();
  endtask

  task automatic test_halt();
    mem[7] = 14'h3C00;
    do_reset();
    start_in = 1'b1;
    advance();
    start_in = 1'b0;
    for (int i = 0; i < 7; i++) advance();
    stall_in = 1'b1;
    settle();
    n_cmp++; if (pc_out !== 8'h07 || instruction_out !== 14'h3C00 || valid_out !== 1'b1) begin
      n_bad++; $display("[TB] FAIL halt_present: got pc=%h instr=%h v=%b expected 07/3C00/1", pc_out, instruction_out, valid_out);
    end
    advance();
    stall_in = 1'b0;
    settle();
    n_cmp++; if (halted_out !== 1'b0 || valid_out !== 1'b1) begin n_bad++; $display("[TB] FAIL halt_stalled: got h=%b v=%b expected 0/1", halted_out, valid_out); end
    n_cmp++; if (imem_addr_out !== 8'h07) begin n_bad++; $display("[TB] FAIL halt_addr: got %h expected 07", imem_addr_out); end
    advance();
    start_in = 1'b1; branch_taken_in = 1'b1; branch_target_in = 8'h22;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_cmp++; if (halted_out !== 1'b1 || valid_out !== 1'b0 || pc_out !== 8'h07 || imem_addr_out !== 8'h07 || instruction_out !== 14'h0000) begin
        n_bad++; $display("[TB] FAIL halt_hold%0d: got h=%b v=%b pc=%h addr=%h instr=%h expected 1/0/07/07/0000", k, halted_out, valid_out, pc_out, imem_addr_out, instruction_out);
      end
      advance();
    end
    n_cmp++; if (fetch_count_out !== 16'd8) begin n_bad++; $display("[TB] FAIL halt_count: got %0d expected 8", fetch_count_out); end
    start_in = 1'b0; branch_taken_in = 1'b0;
    mem[7] = 14'h0017;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc;
    do_reset();
    start_in = 1'b1;
    advance();
    start_in = 1'b0;
    branch_taken_in = 1'b1; branch_target_in = 8'hFE;
    advance();
    branch_taken_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 8'hFE + 8'(i);
      settle();
      n_cmp++; if (pc_out !== exp_pc || instruction_out !== mem[exp_pc] || valid_out !== 1'b1) begin
        n_bad++; $display("[TB] FAIL wrap%0d: got pc=%h instr=%h v=%b expected %h/%h/1", i, pc_out, instruction_out, valid_out, exp_pc, mem[exp_pc]);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; branch_taken_in = 1'b1; branch_target_in = 8'h80;
    settle();
    n_cmp++; if (imem_addr_out !== 8'h00) begin n_bad++; $display("[TB] FAIL rstmid_addr: got %h expected 00", imem_addr_out); end
    advance();
    rst = 1'b0; branch_taken_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      n_cmp++; if (pc_out !== 8'h00 || valid_out !== 1'b0 || fetch_count_out !== 16'h0000 || halted_out !== 1'b0 || imem_addr_out !== 8'h00) begin
        n_bad++; $display("[TB] FAIL rstmid_state%0d: got pc=%h v=%b cnt=%h h=%b addr=%h expected 00/0/0000/0/00", k, pc_out, valid_out, fetch_count_out, halted_out, imem_addr_out);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [13:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 14'($urandom);
      w[13:10] = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      mem[i] = w;
    end
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst              = ($urandom_range(0, 99) == 0) || (c % 150 == 149);
      start_in         = ($urandom_range(0, 3) == 0);
      stall_in         = ($urandom_range(0, 3) == 0);
      branch_taken_in  = ($urandom_range(0, 5) == 0);
      branch_target_in = 8'($urandom);
      settle();
      n_cmp++;
      if ({valid_out, halted_out, pc_out, instruction_out, fetch_count_out, imem_addr_out} !==
          {e_valid, e_halt, e_pc, e_instr, e_count, e_addr}) begin
        n_bad++;
        $display("[TB] FAIL random_c%0d: got v=%b h=%b pc=%h i=%h cnt=%h a=%h expected v=%b h=%b pc=%h i=%h cnt=%h a=%h", c,
                 valid_out, halted_out, pc_out, instruction_out, fetch_count_out, imem_addr_out,
                 e_valid, e_halt, e_pc, e_instr, e_count, e_addr);
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) mem[i] = 14'(i + 16'h10);
    do_reset();
    start_in = 1'b1;
    advance();
    start_in = 1'b0;
    for (int c = 0; c < 65540; c++) advance();
    settle();
    n_cmp++; if (fetch_count_out !== 16'hFFFF || valid_out !== 1'b1) begin
      n_bad++; $display("[TB] FAIL count_saturate: got cnt=%h v=%b expected FFFF/1", fetch_count_out, valid_out);
    end
    n_cmp++; if (fetch_count_out !== e_count) begin n_bad++; $display("[TB] FAIL count_model: got %h expected %h", fetch_count_out, e_count); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 14'(i + 16'h10);
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
